// File: rtl/circle_sprite_engine.sv
// circle_sprite_engine: keypad-edited filled circles rendered through a 2-stage pixel pipeline.
// Optional feature macro: SPRITE_HILITE_EN draws the selected object in inverted colour.

module circle_sprite_lane (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  x,
    input  logic [8:0]  y,
    input  logic [9:0]  r,
    input  logic [9:0]  col,
    input  logic [8:0]  row,
    output logic [9:0]  dx,
    output logic [8:0]  dy,
    output logic [19:0] r2
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dx <= '0;
            dy <= '0;
            r2 <= '0;
        end else begin
            dx <= (x >= col) ? x - col : col - x;
            dy <= (y >= row) ? y - row : row - y;
            r2 <= {10'd0, r} * {10'd0, r};
        end
    end
endmodule

module circle_sprite_engine #(
    parameter int N_OBJ  = 4,
    parameter int STEP   = 20,
    parameter int R_STEP = 5,
    parameter int R_MIN  = 5,
    parameter int R_MAX  = 100,
    parameter int H_RES  = 640,
    parameter int V_RES  = 480
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            key_code,
    input  logic                  key_ready,
    input  logic [9:0]            col_addr,
    input  logic [8:0]            row_addr,
    input  logic [12*N_OBJ-1:0]   obj_color,
    input  logic [11:0]           bg_color,
    output logic [11:0]           pix_data,
    output logic [2:0]            sel,
    output logic [9:0]            sel_x,
    output logic [8:0]            sel_y,
    output logic [9:0]            sel_r
);
    localparam int SW = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
    localparam logic [9:0] STEP_X = 10'(STEP);
    localparam logic [8:0] STEP_Y = 9'(STEP);
    localparam logic [9:0] X_HI   = 10'(H_RES - 1);
    localparam logic [8:0] Y_HI   = 9'(V_RES - 1);
    localparam logic [9:0] RS     = 10'(R_STEP);
    localparam logic [9:0] RMIN   = 10'(R_MIN);
    localparam logic [9:0] RMAX   = 10'(R_MAX);
    localparam logic [8:0] Y0     = 9'(V_RES / 2);
    localparam logic [9:0] R0     = 10'd15;

    function automatic logic [9:0] x_init(input int i);
        return 10'((H_RES / (N_OBJ + 1)) * (i + 1));
    endfunction

    logic [N_OBJ-1:0][9:0] x_q;
    logic [N_OBJ-1:0][8:0] y_q;
    logic [N_OBJ-1:0][9:0] r_q;
    logic [SW-1:0]         sel_q;
    logic                  kr_q;
    logic                  s1_vld;

    // Saturating edits compare against the limit first so nothing wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kr_q  <= 1'b0;
            sel_q <= '0;
            for (int i = 0; i < N_OBJ; i++) begin
                x_q[i] <= x_init(i);
                y_q[i] <= Y0;
                r_q[i] <= R0;
            end
        end else begin
            kr_q <= key_ready;
            if (key_ready && !kr_q) begin
                case (key_code)
                    5'h0C: x_q[sel_q] <= (x_q[sel_q] < STEP_X) ? '0 : x_q[sel_q] - STEP_X;
                    5'h0E: x_q[sel_q] <= (x_q[sel_q] > X_HI - STEP_X) ? X_HI : x_q[sel_q] + STEP_X;
                    5'h09: y_q[sel_q] <= (y_q[sel_q] < STEP_Y) ? '0 : y_q[sel_q] - STEP_Y;
                    5'h11: y_q[sel_q] <= (y_q[sel_q] > Y_HI - STEP_Y) ? Y_HI : y_q[sel_q] + STEP_Y;
                    5'h10: r_q[sel_q] <= (r_q[sel_q] < RMIN + RS) ? RMIN : r_q[sel_q] - RS;
                    5'h12: r_q[sel_q] <= (r_q[sel_q] > RMAX - RS) ? RMAX : r_q[sel_q] + RS;
                    5'h0D: sel_q <= (sel_q == SW'(N_OBJ - 1)) ? '0 : sel_q + 1'b1;
                    5'h0F: begin
                        x_q[sel_q] <= x_init(int'(sel_q));
                        y_q[sel_q] <= Y0;
                        r_q[sel_q] <= R0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sel   = 3'(sel_q);
    assign sel_x = x_q[sel_q];
    assign sel_y = y_q[sel_q];
    assign sel_r = r_q[sel_q];

    logic [N_OBJ-1:0] hit;

    genvar g;
    generate
        for (g = 0; g < N_OBJ; g++) begin : g_lane
            logic [9:0]  dx_s1;
            logic [8:0]  dy_s1;
            logic [19:0] r2_s1;
            logic [19:0] dx2, dy2;
            logic [20:0] d2;

            circle_sprite_lane u_lane (
                .clk (clk),
                .rst (rst),
                .x   (x_q[g]),
                .y   (y_q[g]),
                .r   (r_q[g]),
                .col (col_addr),
                .row (row_addr),
                .dx  (dx_s1),
                .dy  (dy_s1),
                .r2  (r2_s1)
            );

            assign dx2    = {10'd0, dx_s1} * {10'd0, dx_s1};
            assign dy2    = {11'd0, dy_s1} * {11'd0, dy_s1};
            assign d2     = {1'b0, dx2} + {1'b0, dy2};
            assign hit[g] = d2 < {1'b0, r2_s1};
        end
    endgenerate

    // Walk high-to-low so the lowest-index hit wins.
    logic [11:0] pix_next;
    always_comb begin
        pix_next = bg_color;
        for (int i = N_OBJ - 1; i >= 0; i--) begin
            if (hit[i]) begin
                pix_next = obj_color[12*i +: 12];
`ifdef SPRITE_HILITE_EN
                if (SW'(i) == sel_q) pix_next = ~obj_color[12*i +: 12];
`endif
            end
        end
    end

    // Stage 1 holds reset zeros for one edge after release; keep pix_data at 0 until it is real.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld   <= 1'b0;
            pix_data <= '0;
        end else begin
            s1_vld   <= 1'b1;
            pix_data <= s1_vld ? pix_next : 12'h000;
        end
    end
endmodule

// File: tb/tb_circle_sprite_engine.sv
// Directed bench for circle_sprite_engine: table of key edits plus pixel/reset sequences.
module tb_circle_sprite_engine;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  key_code = '0;
    logic        key_ready = 1'b0;
    logic [9:0]  col_addr = '0;
    logic [8:0]  row_addr = '0;
    logic [47:0] obj_color;
    logic [11:0] bg_color;
    logic [11:0] pix_data;
    logic [2:0]  sel;
    logic [9:0]  sel_x;
    logic [8:0]  sel_y;
    logic [9:0]  sel_r;

`ifdef SPRITE_HILITE_EN
    localparam bit HL = 1'b1;
`else
    localparam bit HL = 1'b0;
`endif

    circle_sprite_engine dut (
        .clk(clk), .rst(rst), .key_code(key_code), .key_ready(key_ready),
        .col_addr(col_addr), .row_addr(row_addr), .obj_color(obj_color),
        .bg_color(bg_color), .pix_data(pix_data), .sel(sel),
        .sel_x(sel_x), .sel_y(sel_y), .sel_r(sel_r)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0] code;
        int x, y, r, s;
    } vec_t;
    vec_t tv[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [4:0] c);
        key_code  = c;
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
        tick();
    endtask

    task automatic scan(input int c, input int r);
        col_addr = 10'(c);
        row_addr = 9'(r);
        tick();
        tick();
    endtask

    function automatic logic [11:0] hl(input logic [11:0] c, input bit s);
        return (HL && s) ? ~c : c;
    endfunction

    task automatic add(input logic [4:0] c, input int x, input int y, input int r, input int s);
        vec_t v;
        v.code = c; v.x = x; v.y = y; v.r = r; v.s = s;
        tv.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        obj_color = {12'h0AA, 12'h00F, 12'h0F0, 12'hF00};
        bg_color  = 12'hFFF;

        add(5'h0C, 108, 240, 15, 0); add(5'h0C, 88, 240, 15, 0);
        add(5'h0C, 68, 240, 15, 0);  add(5'h0C, 48, 240, 15, 0);
        add(5'h0C, 28, 240, 15, 0);  add(5'h0C, 8, 240, 15, 0);
        add(5'h0C, 0, 240, 15, 0);   add(5'h0C, 0, 240, 15, 0);
        add(5'h0E, 20, 240, 15, 0);  add(5'h09, 20, 220, 15, 0);
        add(5'h11, 20, 240, 15, 0);  add(5'h10, 20, 240, 10, 0);
        add(5'h10, 20, 240, 5, 0);   add(5'h10, 20, 240, 5, 0);
        add(5'h12, 20, 240, 10, 0);  add(5'h0F, 128, 240, 15, 0);
        add(5'h00, 128, 240, 15, 0); add(5'h13, 128, 240, 15, 0);
        add(5'h0D, 256, 240, 15, 1); add(5'h0E, 276, 240, 15, 1);
        add(5'h0F, 256, 240, 15, 1); add(5'h0D, 384, 240, 15, 2);
        add(5'h0D, 512, 240, 15, 3); add(5'h0D, 128, 240, 15, 0);

        // reset state
        col_addr = 10'd128; row_addr = 9'd240;
        tick(); tick();
        chk("rst_sel", sel, 0);
        chk("rst_x", sel_x, 128);
        chk("rst_y", sel_y, 240);
        chk("rst_r", sel_r, 15);
        chk("rst_pix", pix_data, 0);
        rst = 1'b0;
        tick();
        chk("rel_pix_1edge", pix_data, 0);
        tick();
        chk("rel_pix_2edge", pix_data, hl(12'hF00, 1));

        // pixel boundary and latency
        scan(128, 255);
        chk("edge_d2_eq_r2", pix_data, 12'hFFF);
        scan(128, 254);
        chk("edge_inside", pix_data, hl(12'hF00, 1));
        scan(0, 0);
        chk("bg_far", pix_data, 12'hFFF);
        col_addr = 10'd128; row_addr = 9'd240;
        tick();
        chk("lat_1edge_old", pix_data, 12'hFFF);
        tick();
        chk("lat_2edge_new", pix_data, hl(12'hF00, 1));

        // table-driven key edits
        foreach (tv[i]) begin
            press(tv[i].code);
            chk($sformatf("tv%0d_x", i), sel_x, tv[i].x);
            chk($sformatf("tv%0d_y", i), sel_y, tv[i].y);
            chk($sformatf("tv%0d_r", i), sel_r, tv[i].r);
            chk($sformatf("tv%0d_sel", i), sel, tv[i].s);
        end

        // radius ceiling
        repeat (16) press(5'h12);
        chk("r_95", sel_r, 95);
        press(5'h12);
        chk("r_100", sel_r, 100);
        press(5'h12);
        chk("r_hold100", sel_r, 100);
        press(5'h0F);

        // y ceiling and floor
        repeat (11) press(5'h11);
        chk("y_460", sel_y, 460);
        press(5'h11);
        chk("y_479", sel_y, 479);
        press(5'h11);
        chk("y_hold479", sel_y, 479);
        press(5'h0F);
        repeat (13) press(5'h09);
        chk("y_floor0", sel_y, 0);
        press(5'h0F);

        // selection wrap
        for (int i = 0; i < 4; i++) begin
            press(5'h0D);
            chk($sformatf("sel_step%0d", i), sel, (i + 1) % 4);
        end

        // held key_ready gives one event
        key_code = 5'h0D; key_ready = 1'b1;
        repeat (50) tick();
        key_ready = 1'b0;
        tick();
        chk("hold_one_event", sel, 1);
        repeat (3) press(5'h0D);
        chk("sel_back0", sel, 0);

        // overlap: both object 0 and object 1 parked at (0,240)
        repeat (7) press(5'h0C);
        chk("obj0_x0", sel_x, 0);
        press(5'h0D);
        repeat (13) press(5'h0C);
        chk("obj1_x0", sel_x, 0);
        press(5'h12);
        chk("obj1_r20", sel_r, 20);
        scan(0, 240);
        chk("overlap_sel1", pix_data, hl(12'hF00, 0));
        repeat (3) press(5'h0D);
        scan(0, 240);
        chk("overlap_sel0", pix_data, hl(12'hF00, 1));
        press(5'h0D);
        scan(0, 258);
        chk("obj1_only", pix_data, hl(12'h0F0, 1));

        // geometry change reaches pix_data two edges after the event
        key_code = 5'h10; key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
        chk("shrink_r", sel_r, 15);
        tick();
        chk("shrink_old_geom", pix_data, hl(12'h0F0, 1));
        tick();
        chk("shrink_new_geom", pix_data, 12'hFFF);

        // mid-operation reset
        rst = 1'b1;
        #1;
        chk("mid_rst_pix", pix_data, 0);
        chk("mid_rst_sel", sel, 0);
        chk("mid_rst_x", sel_x, 128);
        chk("mid_rst_r", sel_r, 15);
        tick();
        rst = 1'b0;
        col_addr = 10'd128; row_addr = 9'd240;
        tick();
        chk("mid_rel_1edge", pix_data, 0);
        tick();
        chk("mid_rel_2edge", pix_data, hl(12'hF00, 1));
        press(5'h0D);
        chk("mid_obj1_x", sel_x, 256);
        chk("mid_obj1_r", sel_r, 15);
        press(5'h0D);
        chk("mid_obj2_x", sel_x, 384);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/circle_sprite_engine.md
# circle_sprite_engine

Parametrised keypad-driven sprite renderer: holds N independently movable, resizable filled circles and produces the 12-bit VGA pixel colour for the current scan address. It sits between the keypad decoder and the `vgac` display controller. Keypad edges select the active object and edit its position and radius with saturating arithmetic. The pixel path is a 2-stage pipeline with fixed priority among overlapping objects.

## Interface
Parameters:
- `N_OBJ`, 4: number of circle objects (1–8).
- `STEP`, 20: pixels moved per X/Y key press.
- `R_STEP`, 5: radius change per key press.
- `R_MIN`, 5; `R_MAX`, 100: radius saturation limits.
- `H_RES`, 640; `V_RES`, 480: visible area; positions clamp to [0, H_RES-1] and [0, V_RES-1].

Ports:
- `clk` in 1: system clock; all state on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `key_code` in 5: keypad code, valid while `key_ready` is high.
- `key_ready` in 1: keypad ready level; rising edge = one key event.
- `col_addr` in 10, `row_addr` in 9: current VGA scan address.
- `obj_color` in 12*N_OBJ: object i colour in bits [12i+11:12i].
- `bg_color` in 12: background colour.
- `pix_data` out 12: registered pixel colour.
- `sel` out 3: index of the selected object.
- `sel_x` out 10, `sel_y` out 9, `sel_r` out 10: selected object's parameters, for the seven-segment display.

## Operation
- Reset: `sel`=0. Object i: x = (H_RES/(N_OBJ+1))*(i+1), y = V_RES/2, r = 15. `pix_data`=0. Internal `key_ready` history register = 0.
- Key event: registered `key_ready` is 0 and current `key_ready` is 1. Exactly one action per event. The action applies to the selected object and is visible at the next edge.
- Decode:
  - 0x0C: x -= STEP, floor 0.
  - 0x0E: x += STEP, ceiling H_RES-1.
  - 0x09: y -= STEP, floor 0.
  - 0x11: y += STEP, ceiling V_RES-1.
  - 0x10: r -= R_STEP, floor R_MIN.
  - 0x12: r += R_STEP, ceiling R_MAX.
  - 0x0D: sel = (sel+1) mod N_OBJ.
  - 0x0F: restore the selected object's reset values.
  - Other codes: ignored.
- Saturation compares before subtracting, so there is no wrap-around. For example, x=10 with STEP=20 gives x=0.
- Pixel pipeline:
  - Stage 1 registers the per-object absolute differences |x−col| (10 bits) and |y−row| (9 bits), plus r² (20 bits).
  - Stage 2 computes dx²+dy² in 21 bits. An object hits when this sum is strictly less than r².
  - The lowest-index hit object supplies the colour; with no hit, the output is `bg_color`. The result is registered into `pix_data`.
- `sel_x`, `sel_y` and `sel_r` are combinational views of the selected object's registers.

## Timing
- `pix_data` latency is 2 `clk` cycles from `col_addr`/`row_addr`. The caller compensates for this with sync delay or accepts a 2-pixel shift.
- A key event at edge k updates the registers at edge k, so the new geometry affects `pix_data` from edge k+2. Pixels already in the pipeline use the old geometry.
- A held `key_ready` gives exactly one event. Another event requires `key_ready` to go low for at least one cycle.
- Reset asserted mid-operation clears all state immediately, including both pipeline stages. The first valid `pix_data` appears 2 edges after `rst` deasserts.
- Selection change and edit never happen together, because each event has one code.

## Configuration
- `SPRITE_HILITE_EN` defined: a hit on the selected object outputs `~obj_color[sel]`, a bitwise inversion, so the object being edited is visible.
- Not defined: the selected object uses its normal colour. `sel` and the readback outputs still function.

## Test plan
- Reset with N_OBJ=4: `sel`=0, `sel_x`=128, `sel_y`=240, `sel_r`=15; `pix_data`=0 until 2 cycles after release.
- Scan (128,240) with obj_color[0]=0xF00 and bg=0xFFF: `pix_data`=0xF00 two cycles later. Scan (128,255), where d²=225 is not < 225: `pix_data`=0xFFF.
- Seven 0x0C events on object 0: x goes 108, 88, … 8, then saturates at 0. Also 0x12 from r=95 → 100, then held at 100.
- Send 0x0D four times: `sel` goes 1, 2, 3, 0. Holding `key_ready` high for 50 cycles produces only one increment.
- Overlap: move object 1 onto object 0's centre and scan there. `pix_data` = obj_color[0]. With `SPRITE_HILITE_EN` and sel=1, the result is still obj_color[0]; with sel=0, it is ~obj_color[0].
- Assert `rst` mid-frame after edits: all objects are back at defaults, `pix_data`=0 in the same cycle, and the pipeline refills after 2 edges.
